// File: rtl/fwd_hazard_unit.sv
// ID/EX operand forwarding with load-use stall control for the 5-stage RV32 pipeline.
// Define FWD_HAZARD_STATS_EN to build the saturating forward/stall statistics counters.
//
// state | meaning
// IDLE  | normal flow; stall_o follows the combinational load-use hazard
// STALL | extra load-use stall cycles while the load result moves on to WB
module fwd_hazard_unit #(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int NRD        = 2,
  parameter int LOAD_STALL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  id_valid,
  input  logic [NRD*REG_AW-1:0] id_rs,
  input  logic [NRD-1:0]        id_use,
  input  logic [NRD*XLEN-1:0]   id_rf_data,
  input  logic [REG_AW-1:0]     ex_wr,
  input  logic [REG_AW-1:0]     mem_wr,
  input  logic [REG_AW-1:0]     wb_wr,
  input  logic                  ex_we,
  input  logic                  mem_we,
  input  logic                  wb_we,
  input  logic                  ex_is_load,
  input  logic [XLEN-1:0]       ex_result,
  input  logic [XLEN-1:0]       mem_result,
  input  logic [XLEN-1:0]       wb_result,
  output logic                  stall_o,
  output logic                  ex_valid_o,
  output logic [NRD*XLEN-1:0]   ex_op,
  output logic [NRD*2-1:0]      fwd_sel,
  output logic [31:0]           stat_fwd_cnt,
  output logic [31:0]           stat_stall_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL - 1);

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          cnt;
  logic [2:0]          cnt_nxt;
  logic [NRD-1:0]      m_ex;
  logic [NRD-1:0]      m_mem;
  logic [NRD-1:0]      m_wb;
  logic [NRD*XLEN-1:0] op_nxt;
  logic [NRD*2-1:0]    sel_nxt;
  logic                hazard;

  // x0 is hard-wired zero, so a write to it is never a forwarding source.
  always_comb begin
    m_ex    = '0;
    m_mem   = '0;
    m_wb    = '0;
    op_nxt  = '0;
    sel_nxt = '0;
    for (int i = 0; i < NRD; i++) begin
      m_ex[i]  = id_use[i] && (id_rs[i*REG_AW +: REG_AW] != '0) && ex_we
                 && (id_rs[i*REG_AW +: REG_AW] == ex_wr);
      m_mem[i] = id_use[i] && (id_rs[i*REG_AW +: REG_AW] != '0) && mem_we
                 && (id_rs[i*REG_AW +: REG_AW] == mem_wr);
      m_wb[i]  = id_use[i] && (id_rs[i*REG_AW +: REG_AW] != '0) && wb_we
                 && (id_rs[i*REG_AW +: REG_AW] == wb_wr);
      if (m_ex[i]) begin
        op_nxt[i*XLEN +: XLEN] = ex_result;
        sel_nxt[i*2 +: 2]      = 2'd3;
      end else if (m_mem[i]) begin
        op_nxt[i*XLEN +: XLEN] = mem_result;
        sel_nxt[i*2 +: 2]      = 2'd2;
      end else if (m_wb[i]) begin
        op_nxt[i*XLEN +: XLEN] = wb_result;
        sel_nxt[i*2 +: 2]      = 2'd1;
      end else begin
        op_nxt[i*XLEN +: XLEN] = id_rf_data[i*XLEN +: XLEN];
        sel_nxt[i*2 +: 2]      = 2'd0;
      end
    end
  end

  // A load in EX only has an address on ex_result, never its data.
  assign hazard = id_valid && ex_is_load && (|m_ex);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_o   = 1'b0;
    if (flush_i) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          stall_o = hazard;
          if (hazard && (LOAD_STALL > 1)) begin
            state_nxt = STALL;
            cnt_nxt   = CNT_INIT;
          end
        end
        STALL: begin
          stall_o = 1'b1;
          cnt_nxt = cnt - 3'd1;
          if (cnt == 3'd1) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ex_valid_o <= 1'b0;
      ex_op      <= '0;
      fwd_sel    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (flush_i) begin
        ex_valid_o <= 1'b0;
      end else begin
        ex_valid_o <= id_valid && !stall_o;
        if (!stall_o) begin
          ex_op   <= op_nxt;
          fwd_sel <= sel_nxt;
        end
      end
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] fwd_cnt_q;
  logic [31:0] stall_cnt_q;
  logic [2:0]  n_fwd;
  logic [32:0] fwd_sum;

  always_comb begin
    n_fwd = '0;
    for (int i = 0; i < NRD; i++) begin
      n_fwd = n_fwd + {2'b00, (sel_nxt[i*2 +: 2] != 2'd0)};
    end
  end

  assign fwd_sum = {1'b0, fwd_cnt_q} + {30'd0, n_fwd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (!flush_i && id_valid && !stall_o) begin
        fwd_cnt_q <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
      end
      if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign stat_fwd_cnt   = fwd_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  assign stat_fwd_cnt   = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit; two instances cover LOAD_STALL=1 and LOAD_STALL=3.
module tb_fwd_hazard_unit;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NRD    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_use;
  logic [63:0] id_rf_data;
  logic [4:0]  ex_wr, mem_wr, wb_wr;
  logic        ex_we, mem_we, wb_we, ex_is_load;
  logic [31:0] ex_result, mem_result, wb_result;

  logic        stall1, exv1, stall3, exv3;
  logic [63:0] op1, op3;
  logic [3:0]  sel1, sel3;
  logic [31:0] sf1, ss1, sf3, ss3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        v;
    logic [63:0] op;
    logic [3:0]  sel;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fwd_hazard_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .NRD(NRD), .LOAD_STALL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .id_valid(id_valid), .id_rs(id_rs),
    .id_use(id_use), .id_rf_data(id_rf_data), .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .ex_is_load(ex_is_load),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .stall_o(stall1), .ex_valid_o(exv1), .ex_op(op1), .fwd_sel(sel1),
    .stat_fwd_cnt(sf1), .stat_stall_cnt(ss1));

  fwd_hazard_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .NRD(NRD), .LOAD_STALL(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .id_valid(id_valid), .id_rs(id_rs),
    .id_use(id_use), .id_rf_data(id_rf_data), .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .ex_is_load(ex_is_load),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .stall_o(stall3), .ex_valid_o(exv3), .ex_op(op3), .fwd_sel(sel3),
    .stat_fwd_cnt(sf3), .stat_stall_cnt(ss3));

  task automatic clear_inputs();
    flush_i = 1'b0; id_valid = 1'b0; id_rs = '0; id_use = '0; id_rf_data = '0;
    ex_wr = '0; mem_wr = '0; wb_wr = '0; ex_we = 1'b0; mem_we = 1'b0; wb_we = 1'b0;
    ex_is_load = 1'b0; ex_result = '0; mem_result = '0; wb_result = '0;
  endtask

  task automatic set_id(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] use_b,
                        input logic [31:0] d0, input logic [31:0] d1);
    id_valid = 1'b1; id_rs = {rs1, rs0}; id_use = use_b; id_rf_data = {d1, d0};
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference priority: newest writer of a non-zero, actually-read register wins.
  function automatic exp_t model();
    exp_t e;
    logic [4:0] rs;
    logic       u;
    e = '0;
    e.v = id_valid;
    for (int i = 0; i < 2; i++) begin
      rs = id_rs[i*5 +: 5];
      u  = id_use[i] && (rs != 5'd0);
      if (u && ex_we && rs == ex_wr) begin
        e.op[i*32 +: 32] = ex_result;  e.sel[i*2 +: 2] = 2'd3;
      end else if (u && mem_we && rs == mem_wr) begin
        e.op[i*32 +: 32] = mem_result; e.sel[i*2 +: 2] = 2'd2;
      end else if (u && wb_we && rs == wb_wr) begin
        e.op[i*32 +: 32] = wb_result;  e.sel[i*2 +: 2] = 2'd1;
      end else begin
        e.op[i*32 +: 32] = id_rf_data[i*32 +: 32]; e.sel[i*2 +: 2] = 2'd0;
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    set_id(5'd3, 5'd4, 2'b11, 32'h11, 32'h22);
    tick();
    checks++;
    if ({stall1, exv1, op1, sel1, sf1, ss1} !== '0) begin
      errors++;
      $display("FAIL reset dut1 got stall=%0b v=%0b op=%h sel=%h sf=%0d ss=%0d exp all 0",
               stall1, exv1, op1, sel1, sf1, ss1);
    end
    checks++;
    if ({stall3, exv3, op3, sel3, sf3, ss3} !== '0) begin
      errors++;
      $display("FAIL reset dut3 got stall=%0b v=%0b op=%h sel=%h sf=%0d ss=%0d exp all 0",
               stall3, exv3, op3, sel3, sf3, ss3);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_no_match();
    exp_t e;
    @(negedge clk);
    clear_inputs();
    set_id(5'd3, 5'd4, 2'b11, 32'h11, 32'h22);
    exp_q.push_back('{v: 1'b1, op: {32'h22, 32'h11}, sel: 4'b0000});
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({exv1, op1, sel1} !== {e.v, e.op, e.sel}) begin
      errors++;
      $display("FAIL no_match dut1 got v=%0b op=%h sel=%h exp v=%0b op=%h sel=%h",
               exv1, op1, sel1, e.v, e.op, e.sel);
    end
    checks++;
    if ({exv3, op3, sel3} !== {e.v, e.op, e.sel}) begin
      errors++;
      $display("FAIL no_match dut3 got v=%0b op=%h sel=%h exp v=%0b op=%h sel=%h",
               exv3, op3, sel3, e.v, e.op, e.sel);
    end
  endtask

  task automatic test_priority();
    logic [3:0]  ctl [6];
    logic [31:0] eop [6];
    logic [1:0]  esel [6];
    exp_t e;
    ctl  = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b1011, 4'b1110};
    eop  = '{32'hA, 32'hB, 32'hC, 32'h55, 32'hA, 32'h55};
    esel = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd0};
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      clear_inputs();
      set_id(5'd5, 5'd9, {1'b1, ctl[r][0]}, 32'h55, 32'h99);
      ex_wr = 5'd5; mem_wr = 5'd5; wb_wr = 5'd5;
      ex_result = 32'hA; mem_result = 32'hB; wb_result = 32'hC;
      {ex_we, mem_we, wb_we} = ctl[r][3:1];
      exp_q.push_back('{v: 1'b1, op: {32'h99, eop[r]}, sel: {2'd0, esel[r]}});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({exv1, op1, sel1} !== {e.v, e.op, e.sel}) begin
        errors++;
        $display("FAIL priority[%0d] dut1 got v=%0b op=%h sel=%h exp v=%0b op=%h sel=%h",
                 r, exv1, op1, sel1, e.v, e.op, e.sel);
      end
    end
  endtask

  task automatic test_x0_guard();
    exp_t e;
    @(negedge clk);
    clear_inputs();
    set_id(5'd0, 5'd3, 2'b11, 32'h77, 32'h33);
    ex_wr = 5'd0; ex_we = 1'b1; ex_is_load = 1'b1; ex_result = 32'hDEAD;
    mem_wr = 5'd0; mem_we = 1'b1; mem_result = 32'hBEEF;
    wb_wr = 5'd0; wb_we = 1'b1; wb_result = 32'hCAFE;
    #1;
    checks++;
    if ({stall1, stall3} !== 2'b00) begin
      errors++;
      $display("FAIL x0_stall got stall1=%0b stall3=%0b exp 0 0", stall1, stall3);
    end
    exp_q.push_back('{v: 1'b1, op: {32'h33, 32'h77}, sel: 4'b0000});
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({exv1, op1, sel1} !== {e.v, e.op, e.sel}) begin
      errors++;
      $display("FAIL x0_guard dut1 got v=%0b op=%h sel=%h exp v=%0b op=%h sel=%h",
               exv1, op1, sel1, e.v, e.op, e.sel);
    end
  endtask

  task automatic test_same_addr();
    logic [1:0]  use_t [3];
    logic [63:0] eop [3];
    logic [3:0]  esel [3];
    exp_t e;
    use_t = '{2'b01, 2'b10, 2'b11};
    eop   = '{{32'h99, 32'hA}, {32'hA, 32'h55}, {32'hB, 32'hB}};
    esel  = '{4'b0011, 4'b1100, 4'b1010};
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      clear_inputs();
      set_id(5'd5, 5'd5, use_t[r], 32'h55, 32'h99);
      ex_wr = 5'd5; ex_we = (r != 2); ex_result = 32'hA;
      mem_wr = 5'd5; mem_we = 1'b1; mem_result = 32'hB;
      exp_q.push_back('{v: 1'b1, op: eop[r], sel: esel[r]});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({exv1, op1, sel1} !== {e.v, e.op, e.sel}) begin
        errors++;
        $display("FAIL same_addr[%0d] dut1 got v=%0b op=%h sel=%h exp v=%0b op=%h sel=%h",
                 r, exv1, op1, sel1, e.v, e.op, e.sel);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int r = 0; r < 24; r++) begin
      @(negedge clk);
      clear_inputs();
      set_id(5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
             $urandom, $urandom);
      id_valid = ($urandom_range(0, 7) != 0);
      ex_wr = 5'($urandom_range(0, 5)); mem_wr = 5'($urandom_range(0, 5));
      wb_wr = 5'($urandom_range(0, 5));
      ex_we = 1'($urandom_range(0, 1)); mem_we = 1'($urandom_range(0, 1));
      wb_we = 1'($urandom_range(0, 1));
      ex_result = $urandom; mem_result = $urandom; wb_result = $urandom;
      exp_q.push_back(model());
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({exv1, op1, sel1} !== {e.v, e.op, e.sel}) begin
        errors++;
        $display("FAIL b2b[%0d] dut1 got v=%0b op=%h sel=%h exp v=%0b op=%h sel=%h",
                 r, exv1, op1, sel1, e.v, e.op, e.sel);
      end
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    @(negedge clk);
    clear_inputs();
    set_id(5'd2, 5'd7, 2'b11, 32'h20, 32'h70);
    ex_wr = 5'd7; ex_we = 1'b1; ex_is_load = 1'b1; ex_result = 32'hBAD0;
    #1;
    checks++;
    if ({stall1, stall3} !== 2'b11) begin
      errors++;
      $display("FAIL load_hazard got stall1=%0b stall3=%0b exp 1 1", stall1, stall3);
    end
    tick();
    checks++;
    if ({exv1, exv3, op1, op3} !== '0) begin
      errors++;
      $display("FAIL load_bubble got v1=%0b v3=%0b op1=%h op3=%h exp 0 0 0 0", exv1, exv3, op1, op3);
    end
    @(negedge clk);
    ex_we = 1'b0; ex_is_load = 1'b0; ex_wr = 5'd0;
    mem_wr = 5'd7; mem_we = 1'b1; mem_result = 32'h1234;
    #1;
    checks++;
    if ({stall1, stall3} !== 2'b01) begin
      errors++;
      $display("FAIL load_stall_len got stall1=%0b stall3=%0b exp 0 1", stall1, stall3);
    end
    tick();
    checks++;
    if ({exv1, op1, sel1} !== {1'b1, 32'h1234, 32'h20, 4'b1000}) begin
      errors++;
      $display("FAIL load_mem_fwd dut1 got v=%0b op=%h sel=%h exp v=1 op=%h sel=8",
               exv1, op1, sel1, {32'h1234, 32'h20});
    end
    checks++;
    if ({exv3, op3} !== '0) begin
      errors++;
      $display("FAIL load_hold dut3 got v=%0b op=%h exp v=0 op=0", exv3, op3);
    end
    @(negedge clk);
    mem_we = 1'b0; wb_wr = 5'd7; wb_we = 1'b1; wb_result = 32'h5678;
    #1;
    checks++;
    if (stall3 !== 1'b1) begin
      errors++;
      $display("FAIL load_stall3_c3 got %0b exp 1", stall3);
    end
    tick();
    @(negedge clk);
    #1;
    checks++;
    if (stall3 !== 1'b0) begin
      errors++;
      $display("FAIL load_stall3_end got %0b exp 0", stall3);
    end
    tick();
    checks++;
    if ({exv3, op3, sel3} !== {1'b1, 32'h5678, 32'h20, 4'b0100}) begin
      errors++;
      $display("FAIL load_wb_fwd dut3 got v=%0b op=%h sel=%h exp v=1 op=%h sel=4",
               exv3, op3, sel3, {32'h5678, 32'h20});
    end
  endtask

  task automatic test_flush();
    apply_reset();
    @(negedge clk);
    clear_inputs();
    set_id(5'd3, 5'd4, 2'b11, 32'h11, 32'h22);
    tick();
    @(negedge clk);
    set_id(5'd2, 5'd7, 2'b11, 32'h20, 32'h70);
    ex_wr = 5'd7; ex_we = 1'b1; ex_is_load = 1'b1;
    tick();
    @(negedge clk);
    ex_we = 1'b0; ex_is_load = 1'b0; ex_wr = 5'd0;
    mem_wr = 5'd7; mem_we = 1'b1; mem_result = 32'h1234;
    flush_i = 1'b1;
    #1;
    checks++;
    if ({stall1, stall3} !== 2'b00) begin
      errors++;
      $display("FAIL flush_stall got stall1=%0b stall3=%0b exp 0 0", stall1, stall3);
    end
    tick();
    checks++;
    if ({exv3, op3, sel3} !== {1'b0, 32'h22, 32'h11, 4'b0000}) begin
      errors++;
      $display("FAIL flush_hold dut3 got v=%0b op=%h sel=%h exp v=0 op=%h sel=0",
               exv3, op3, sel3, {32'h22, 32'h11});
    end
    checks++;
    if (exv1 !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid dut1 got %0b exp 0", exv1);
    end
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    checks++;
    if (stall3 !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle dut3 stall got %0b exp 0", stall3);
    end
    tick();
    checks++;
    if ({exv3, op3, sel3} !== {1'b1, 32'h1234, 32'h20, 4'b1000}) begin
      errors++;
      $display("FAIL flush_resume dut3 got v=%0b op=%h sel=%h exp v=1 op=%h sel=8",
               exv3, op3, sel3, {32'h1234, 32'h20});
    end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    @(negedge clk);
    clear_inputs();
    set_id(5'd3, 5'd4, 2'b11, 32'h11, 32'h22);
    tick();
    @(negedge clk);
    set_id(5'd2, 5'd7, 2'b11, 32'h20, 32'h70);
    ex_wr = 5'd7; ex_we = 1'b1; ex_is_load = 1'b1;
    tick();
    @(negedge clk);
    ex_we = 1'b0; ex_is_load = 1'b0; ex_wr = 5'd0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall3, exv3, op3, sel3} !== '0) begin
      errors++;
      $display("FAIL rst_mid_stall got stall=%0b v=%0b op=%h sel=%h exp all 0",
               stall3, exv3, op3, sel3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (stall3 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stall_idle got stall=%0b exp 0", stall3);
    end
  endtask

  task automatic test_stats();
    logic [31:0] efwd, estall;
`ifdef FWD_HAZARD_STATS_EN
    efwd = 32'd10; estall = 32'd4;
`else
    efwd = 32'd0; estall = 32'd0;
`endif
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      clear_inputs();
      set_id(5'd5, 5'd6, 2'b11, 32'h0, 32'h0);
      ex_wr = 5'd5; ex_we = 1'b1; ex_result = 32'(k);
      mem_wr = 5'd6; mem_we = 1'b1; mem_result = 32'(k + 100);
      tick();
    end
    @(negedge clk);
    ex_is_load = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    clear_inputs();
    flush_i = 1'b1;
    tick();
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    checks++;
    if ({sf1, ss1} !== {efwd, estall}) begin
      errors++;
      $display("FAIL stats dut1 got fwd=%0d stall=%0d exp fwd=%0d stall=%0d", sf1, ss1, efwd, estall);
    end
    checks++;
    if ({sf3, ss3} !== {efwd, estall}) begin
      errors++;
      $display("FAIL stats dut3 got fwd=%0d stall=%0d exp fwd=%0d stall=%0d", sf3, ss3, efwd, estall);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sf1, ss1, sf3, ss3} !== '0) begin
      errors++;
      $display("FAIL stats_reset got %0d %0d %0d %0d exp all 0", sf1, ss1, sf3, ss3);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_no_match();
    test_priority();
    test_x0_guard();
    test_same_addr();
    test_back_to_back();
    test_load_use();
    test_flush();
    test_reset_mid_stall();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the single-output forwarding logic: per-read-port operand forwarding plus load-use stall control for the 5-stage RV32 pipeline.
- Sits at the ID/EX boundary.
- Compares each ID source register against the EX, MEM and WB destinations, selects the newest value, and registers it as the EX operand.
- A counter-driven FSM stalls ID and injects bubbles while a load result is not yet forwardable.

Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register address width.
- NRD, 2, number of ID read ports (1..3).
- LOAD_STALL, 1, stall cycles per load-use hazard (1..4). With 1, load data is valid on mem_result; with 2 or more, load data is taken from WB.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous pipeline flush (branch/jump redirect)
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  NRD*REG_AW  source addresses; port i at bits [i*REG_AW +: REG_AW]
- id_use  in  NRD  port i actually reads its source
- id_rf_data  in  NRD*XLEN  register-file read data per port
- ex_wr, mem_wr, wb_wr  in  REG_AW each  destination addresses
- ex_we, mem_we, wb_we  in  1 each  stage will write its destination
- ex_is_load  in  1  EX instruction is a load
- ex_result, mem_result, wb_result  in  XLEN each  stage result data
- stall_o  out  1  hold PC and IF/ID
- ex_valid_o  out  1  EX-stage valid; 0 means bubble
- ex_op  out  NRD*XLEN  registered forwarded operands
- fwd_sel  out  NRD*2  registered source per port: 0=RF, 1=WB, 2=MEM, 3=EX
- stat_fwd_cnt  out  32  forwarded-operand count (feature-gated)
- stat_stall_cnt  out  32  stall-cycle count (feature-gated)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, cnt=0.
- Match(stage, i): id_use[i] && id_rs[i]!=0 && stage_we && id_rs[i]==stage_wr. Register x0 is never forwarded.
- Priority per port: EX > MEM > WB > RF.
- Load-use hazard (combinational): id_valid && any i Match(EX, i) && ex_is_load. A loaded value is never forwarded from EX.
- FSM states:
  - IDLE: stall_o = hazard. If hazard and LOAD_STALL>1: go to STALL, cnt <= LOAD_STALL-1. If hazard and LOAD_STALL==1: stay in IDLE.
  - STALL: stall_o=1. If cnt==1 go to IDLE, else cnt--.
- In STALL with LOAD_STALL>=2, the MEM stage result for the load is not used. On return to IDLE the instruction re-evaluates and normally picks WB.
- Rising edge, no flush:
  - ex_valid_o <= id_valid && !stall_o.
  - When !stall_o: ex_op[i] and fwd_sel[i] load the selected source.
  - When stall_o: ex_op and fwd_sel hold.
- Latency: one cycle from ID inputs to ex_op.
- flush_i has highest priority:
  - FSM to IDLE, cnt <= 0, ex_valid_o <= 0.
  - ex_op and fwd_sel hold.
  - stall_o is forced to 0 in the flush cycle.
- Simultaneous matches in several stages: the newest stage wins, e.g. EX over MEM for the same address.
- Ports with the same address may select different sources only if their id_use bits differ.
- Reset asserted mid-stall: immediate return to IDLE and all outputs 0.

Optional Feature:
- FWD_HAZARD_STATS_EN defined:
  - stat_fwd_cnt increments by the number of ports with fwd_sel!=0 on each cycle ex_valid_o is updated to 1.
  - stat_stall_cnt increments each cycle stall_o=1.
  - Both are 32-bit, saturating at 0xFFFF_FFFF, and reset to 0.
- Not defined: both outputs are tied to 0 and no counter logic is generated.

Test Plan:
- No match: rs1=3, rs2=4, all stage we=0, rf_data=0x11/0x22 -> next cycle ex_op=0x11/0x22, fwd_sel=0/0, ex_valid_o=1.
- Priority: rs1=5; EX, MEM and WB all write x5 with 0xA, 0xB, 0xC -> ex_op[0]=0xA, fwd_sel=3. Repeat with ex_we=0 -> 0xB, fwd_sel=2.
- x0 guard: rs1=0, ex_wr=0, ex_we=1, ex_result=0xDEAD -> ex_op[0]=rf_data, fwd_sel=0.
- Load-use: LOAD_STALL=1, ex_is_load, ex_wr=rs2=7 -> stall_o=1 for exactly 1 cycle, one bubble, then ex_op[1]=mem_result. LOAD_STALL=3 -> 3 stall cycles, then WB data selected.
- Flush mid-stall: LOAD_STALL=3, flush_i asserted in the 2nd stall cycle -> stall_o=0 that cycle, FSM returns to IDLE, ex_valid_o=0.
- With FWD_HAZARD_STATS_EN defined: 10 forwarded operands and 4 stall cycles -> stat_fwd_cnt=10, stat_stall_cnt=4. rst_n pulse -> both 0.
